fnd_watch_display: RTL and testbench
====================================

# fnd_watch_display

Drives a 4-digit common-anode 7-segment (FND) display from the watch's binary minute/second outputs. Sits directly downstream of the watch counter. It converts the 8-bit binary `min`/`sec` values to BCD with a sequential double-dabble engine, time-multiplexes the four digits, and flashes a colon dot. A set-mode flag blinks the whole display.

## Interface
- `SCAN_DIV`, 100_000: clocks per digit slot. At 100 MHz this gives 1 kHz per digit.
- `BLINK_DIV`, 50_000_000: clocks per blink half-period (0.5 s at 100 MHz).
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_p`  in  1  reset, asynchronous, active-high.
- `sec`  in  8  binary seconds from watch; valid range 0..59.
- `min`  in  8  binary minutes from watch; valid range 0..59.
- `blink_en`  in  1  set-mode flag; 1 = blink digits.
- `seg_n`  out  8  segments, active-low; [7]=dp, [6:0]={g,f,e,d,c,b,a}.
- `com_n`  out  4  digit anodes, active-low one-hot; [0]=sec ones, [1]=sec tens, [2]=min ones, [3]=min tens.
- `conv_busy`  out  1  high while the BCD converter is not IDLE.

## Operation
- **Snapshot/compare:** registers `snap_sec`/`snap_min` reset to 0. In IDLE, if {min,sec} != {snap_min,snap_sec}, latch the inputs into the snapshot and go to CONV.
- **Converter FSM:** IDLE -> CONV -> DONE -> IDLE.
  - CONV lasts exactly 8 clocks. Sec and min are converted in parallel.
  - Each step: any 4-bit BCD nibble >= 5 gets +3, then the {hundreds,tens,ones,bin} register shifts left 1.
  - DONE lasts 1 clock. It writes the display registers `d_sec_t`, `d_sec_o`, `d_min_t`, `d_min_o`.
- **Input changes during CONV/DONE** are ignored. On return to IDLE the compare re-fires, so the display always converges to the latest input.
- **Out of range:** if a value's hundreds digit is nonzero (value >= 100), both of its digits display dash (g only). Values 60..99 display as-is.
- **Digit font** (seg_n[6:0], hex): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, dash=3F, blank=7F.
- **Scan:**
  - `scan_cnt` counts 0..SCAN_DIV-1 and wraps.
  - On wrap, `dig_idx` advances 0->1->2->3->0.
  - `com_n` = ~(1<<dig_idx).
- **Colon dot:**
  - `blink_cnt` counts 0..BLINK_DIV-1; on wrap it toggles `phase`. The counter is free-running, independent of `blink_en`.
  - seg_n[7] is 0 (lit) only when dig_idx==2 and phase==1.
- **Set mode:**
  - When `blink_en`=1 and phase==0, seg_n = 8'hFF (all blank).
  - When `blink_en`=1 and phase==1, digits show normally and dp is lit on digit 2 regardless.
  - `com_n` keeps scanning in both cases.
- **Reset:** `seg_n`=8'hFF, `com_n`=4'hF, conv_busy=0, state IDLE. dig_idx, scan_cnt, blink_cnt, phase and all snapshot/display registers are 0.

## Timing
- `seg_n`/`com_n` are registered. They reflect dig_idx and display registers one clock after those change. First valid drive is the first edge after reset release (digit 0, "0", dp off).
- **Conversion latency:**
  - Mismatch is detected at edge N.
  - CONV covers edges N+1..N+8.
  - The DONE write happens at edge N+9.
  - The new digit appears on `seg_n` at edge N+10 if that digit is selected, otherwise at its next slot.
- `conv_busy` is high after edge N through edge N+9. It is low after edge N+9.
- **Slot length:** each digit is driven for exactly SCAN_DIV clocks. A full refresh takes 4*SCAN_DIV clocks.
- **Blink period:** `phase` toggles every BLINK_DIV clocks, giving a full period of 2*BLINK_DIV.
- **Async reset mid-conversion:** aborts immediately. Display registers return to 0 and no partial write occurs.
- **Simultaneous edges:** a `blink_en` change and a scan wrap on the same edge both take effect on the next registered output.

## Test plan
Bench parameters: SCAN_DIV=4, BLINK_DIV=16.

1. Reset, then hold sec=0, min=0 -> conv_busy stays 0; com_n cycles E,D,B,7 every 4 clocks; seg_n[6:0]=40 on all digits; dp toggles on digit 2 every 16 clocks.
2. Apply min=23, sec=47 at edge N -> conv_busy high for 9 clocks; display regs are 2,3,4,7 after edge N+9; seg_n[6:0] per slot is 78 (sec ones), 19 (sec tens), 30 (min ones), 24 (min tens).
3. Change sec 47->48 at edge N+3 during CONV -> display first shows 47, then a second conversion starts at edge N+10 and shows 48 after edge N+19.
4. Drive sec=8'd150 -> both sec digits show 3F; min digits unaffected.
5. blink_en=1 with min=5, sec=9 -> seg_n=FF for 16 clocks, then normal digits 10,40,12,40 with dp lit on digit 2 for 16 clocks, repeating.
6. Assert reset_p at edge N+4 of a conversion -> seg_n=FF and com_n=F immediately; conv_busy=0; after release the display shows 00 00 until a mismatch triggers a new conversion.

Source files
------------

// File: rtl/fnd_watch_display.sv
// -----------------------------------------------------------------------------
// fnd_watch_display
//
// Drives a 4-digit common-anode 7-segment display from the watch counter's
// binary minute/second values. A sequential double-dabble engine converts a
// snapshot of {min, sec} to BCD whenever the inputs differ from the last
// converted snapshot. The four digits are time-multiplexed, digit 2 carries a
// flashing colon dot, and set mode blanks the whole display on alternate
// blink phases.
//
// Ports
//   clk        in   system clock, rising edge
//   reset_p    in   asynchronous, active-high reset
//   sec        in   binary seconds (0..59 nominal)
//   min        in   binary minutes (0..59 nominal)
//   blink_en   in   set-mode flag, 1 = blink the digits
//   seg_n      out  segments, active-low, [7]=dp, [6:0]={g,f,e,d,c,b,a}
//   com_n      out  digit anodes, active-low one-hot
//                   [0]=sec ones, [1]=sec tens, [2]=min ones, [3]=min tens
//   conv_busy  out  high while the BCD converter is not idle
// -----------------------------------------------------------------------------
module fnd_watch_display #(
    parameter int SCAN_DIV  = 100_000,
    parameter int BLINK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic [7:0] sec,
    input  logic [7:0] min,
    input  logic       blink_en,
    output logic [7:0] seg_n,
    output logic [3:0] com_n,
    output logic       conv_busy
);

    localparam int SCAN_W  = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);

    // Internal digit code for an out-of-range value; the font maps it to g only.
    localparam logic [3:0] DASH = 4'hA;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t       state;
    logic [2:0]   step;
    logic [7:0]   snap_sec;
    logic [7:0]   snap_min;
    // Double-dabble working registers: {hundreds, tens, ones, binary}.
    logic [19:0]  sh_sec;
    logic [19:0]  sh_min;

    logic [3:0]   d_sec_t;
    logic [3:0]   d_sec_o;
    logic [3:0]   d_min_t;
    logic [3:0]   d_min_o;

    logic [SCAN_W-1:0]  scan_cnt;
    logic [1:0]         dig_idx;
    logic [BLINK_W-1:0] blink_cnt;
    logic               phase;

    logic [3:0]   cur_code;
    logic [7:0]   seg_next;

    // One double-dabble iteration: add 3 to every BCD nibble >= 5, then shift.
    function automatic logic [19:0] dd_step(input logic [19:0] r);
        logic [19:0] a;
        a = r;
        if (a[19:16] >= 4'd5) a[19:16] = a[19:16] + 4'd3;
        if (a[15:12] >= 4'd5) a[15:12] = a[15:12] + 4'd3;
        if (a[11:8]  >= 4'd5) a[11:8]  = a[11:8]  + 4'd3;
        return {a[18:0], 1'b0};
    endfunction

    // Active-low segment pattern {g,f,e,d,c,b,a}.
    function automatic logic [6:0] font(input logic [3:0] code);
        case (code)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            DASH:    return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    // ---------------------------------------------------------------------
    // Snapshot compare and BCD converter. Inputs are only looked at in IDLE;
    // a change during CONV/DONE is picked up by the compare on return to IDLE.
    // ---------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state     <= IDLE;
            conv_busy <= 1'b0;
            step      <= 3'd0;
            snap_sec  <= 8'd0;
            snap_min  <= 8'd0;
            sh_sec    <= 20'd0;
            sh_min    <= 20'd0;
            d_sec_t   <= 4'd0;
            d_sec_o   <= 4'd0;
            d_min_t   <= 4'd0;
            d_min_o   <= 4'd0;
        end else begin
            case (state)
                IDLE: begin
                    if ({min, sec} != {snap_min, snap_sec}) begin
                        snap_sec  <= sec;
                        snap_min  <= min;
                        sh_sec    <= {12'd0, sec};
                        sh_min    <= {12'd0, min};
                        step      <= 3'd0;
                        state     <= CONV;
                        conv_busy <= 1'b1;
                    end
                end
                CONV: begin
                    sh_sec <= dd_step(sh_sec);
                    sh_min <= dd_step(sh_min);
                    step   <= step + 3'd1;
                    if (step == 3'd7) state <= DONE;
                end
                DONE: begin
                    if (sh_sec[19:16] != 4'd0) begin
                        d_sec_t <= DASH;
                        d_sec_o <= DASH;
                    end else begin
                        d_sec_t <= sh_sec[15:12];
                        d_sec_o <= sh_sec[11:8];
                    end
                    if (sh_min[19:16] != 4'd0) begin
                        d_min_t <= DASH;
                        d_min_o <= DASH;
                    end else begin
                        d_min_t <= sh_min[15:12];
                        d_min_o <= sh_min[11:8];
                    end
                    state     <= IDLE;
                    conv_busy <= 1'b0;
                end
                default: begin
                    state     <= IDLE;
                    conv_busy <= 1'b0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Digit scan and colon/blink timebase, both free-running from reset.
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            scan_cnt  <= '0;
            dig_idx   <= 2'd0;
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else begin
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                dig_idx  <= dig_idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------------
    // Output decode; registered below so seg_n/com_n are glitch-free.
    // ---------------------------------------------------------------------
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        cur_code = d_sec_o;
        case (dig_idx)
            2'd0: cur_code = d_sec_o;
            2'd1: cur_code = d_sec_t;
            2'd2: cur_code = d_min_o;
            2'd3: cur_code = d_min_t;
            default: cur_code = d_sec_o;
        endcase

        seg_next = 8'hFF;
        if (!(blink_en && !phase)) begin
            seg_next = {~((dig_idx == 2'd2) && phase), font(cur_code)};
        end
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            seg_n <= 8'hFF;
            com_n <= 4'hF;
        end else begin
            seg_n <= seg_next;
            com_n <= ~(4'b0001 << dig_idx);
        end
    end

endmodule

// File: tb/tb_fnd_watch_display.sv
// -----------------------------------------------------------------------------
// tb_fnd_watch_display
//
// Scoreboard bench for fnd_watch_display with SCAN_DIV=4, BLINK_DIV=16.
// Each scenario task drives inputs and pushes the outputs it expects at
// specific clock edges (counted from reset release); a negedge monitor pops
// and compares them as the edges arrive. Reset values are checked inline.
// -----------------------------------------------------------------------------
module tb_fnd_watch_display;

    localparam int SCAN_DIV  = 4;
    localparam int BLINK_DIV = 16;

    logic       clk = 1'b0;
    logic       reset_p;
    logic [7:0] sec;
    logic [7:0] min;
    logic       blink_en;
    logic [7:0] seg_n;
    logic [3:0] com_n;
    logic       conv_busy;

    int vectors     = 0;
    int miscompares = 0;
    int ec;                                 // rising edges since reset release

    typedef struct {
        int         at;
        logic [3:0] com;
        logic [7:0] seg;
        logic       busy;
        int         id;
    } exp_t;

    exp_t sb[$];

    fnd_watch_display #(
        .SCAN_DIV (SCAN_DIV),
        .BLINK_DIV(BLINK_DIV)
    ) dut (
        .clk      (clk),
        .reset_p  (reset_p),
        .sec      (sec),
        .min      (min),
        .blink_en (blink_en),
        .seg_n    (seg_n),
        .com_n    (com_n),
        .conv_busy(conv_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk or posedge reset_p) begin
        if (reset_p) ec <= 0;
        else         ec <= ec + 1;
    end

    // Font table from the display datasheet; 4'hA stands for dash.
    function automatic logic [6:0] ref_font(input logic [3:0] c);
        case (c)
            4'h0: return 7'h40;
            4'h1: return 7'h79;
            4'h2: return 7'h24;
            4'h3: return 7'h30;
            4'h4: return 7'h19;
            4'h5: return 7'h12;
            4'h6: return 7'h02;
            4'h7: return 7'h78;
            4'h8: return 7'h00;
            4'h9: return 7'h10;
            4'hA: return 7'h3F;
            default: return 7'h7F;
        endcase
    endfunction

    // Outputs after edge t show the slot/phase that held after edge t-1.
    function automatic logic [3:0] exp_com(input int t);
        logic [3:0] one;
        int idx;
        idx = ((t - 1) / SCAN_DIV) % 4;
        one = 4'b0001 << idx;
        return ~one;
    endfunction

    // dig packs {min_t, min_o, sec_t, sec_o}.
    function automatic logic [7:0] exp_seg(input int t, input logic [15:0] dig,
                                           input logic blink);
        int idx;
        int ph;
        idx = ((t - 1) / SCAN_DIV) % 4;
        ph  = ((t - 1) / BLINK_DIV) % 2;
        if (blink && ph == 0) return 8'hFF;
        return {~(idx == 2 && ph == 1), ref_font(dig[idx*4 +: 4])};
    endfunction

    // Expected digits switch to d_new for outputs after edge d_edge+1.
    task automatic push_range(input int t0, input int t1,
                              input logic [15:0] d_old, input logic [15:0] d_new,
                              input int d_edge, input logic blink,
                              input int busy_lo, input int busy_hi, input int id);
        exp_t e;
        for (int t = t0; t <= t1; t++) begin
            e.at   = t;
            e.com  = exp_com(t);
            e.seg  = exp_seg(t, (t - 1 >= d_edge) ? d_new : d_old, blink);
            e.busy = (t >= busy_lo) && (t <= busy_hi);
            e.id   = id;
            sb.push_back(e);
        end
    endtask

    task automatic wait_edge(input int last);
        while (ec < last) @(negedge clk);
        #1;
    endtask

    // Scoreboard consumer.
    exp_t mon_e;
    always @(negedge clk) begin
        if (!reset_p) begin
            while (sb.size() > 0 && sb[0].at <= ec) begin
                mon_e = sb.pop_front();
                if (mon_e.at != ec) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL missed_sample id=%0d edge=%0d now=%0d", mon_e.id, mon_e.at, ec);
                end else begin
                    vectors++;
                    if (com_n !== mon_e.com) begin
                        miscompares++;
                        $display("FAIL com_n id=%0d edge=%0d got=%h want=%h", mon_e.id, ec, com_n, mon_e.com);
                    end
                    vectors++;
                    if (seg_n !== mon_e.seg) begin
                        miscompares++;
                        $display("FAIL seg_n id=%0d edge=%0d got=%h want=%h", mon_e.id, ec, seg_n, mon_e.seg);
                    end
                    vectors++;
                    if (conv_busy !== mon_e.busy) begin
                        miscompares++;
                        $display("FAIL conv_busy id=%0d edge=%0d got=%b want=%b", mon_e.id, ec, conv_busy, mon_e.busy);
                    end
                end
            end
        end
    end

    task automatic check_reset_outputs(input int id);
        vectors++;
        if (seg_n !== 8'hFF) begin
            miscompares++;
            $display("FAIL reset_seg id=%0d got=%h want=ff", id, seg_n);
        end
        vectors++;
        if (com_n !== 4'hF) begin
            miscompares++;
            $display("FAIL reset_com id=%0d got=%h want=f", id, com_n);
        end
        vectors++;
        if (conv_busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_busy id=%0d got=%b want=0", id, conv_busy);
        end
    endtask

    // Idle display 00:00: scan order E,D,B,7 and dp on digit 2 in phase 1.
    task automatic test_reset;
        reset_p  = 1'b1;
        sec      = 8'd0;
        min      = 8'd0;
        blink_en = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs(1);
        reset_p = 1'b0;
        push_range(1, 40, 16'h0000, 16'h0000, 0, 1'b0, 1, 0, 1);
        wait_edge(40);
    endtask

    // 23:47, busy for edges N..N+8, digits visible from edge N+10.
    task automatic test_convert;
        int n;
        n   = ec + 1;
        min = 8'd23;
        sec = 8'd47;
        push_range(n, n + 40, 16'h0000, 16'h2347, n + 9, 1'b0, n, n + 8, 2);
        wait_edge(n + 40);
    endtask

    // Change during CONV is ignored, then converted on return to IDLE.
    task automatic test_change_during_conv;
        int n;
        n   = ec + 1;
        min = 8'd12;
        push_range(n,      n + 9,  16'h2347, 16'h1247, n + 9,  1'b0, n,      n + 8,  3);
        push_range(n + 10, n + 19, 16'h1247, 16'h1247, 0,      1'b0, n + 10, n + 18, 3);
        push_range(n + 20, n + 44, 16'h1247, 16'h1248, n + 19, 1'b0, 1,      0,      3);
        wait_edge(n + 2);
        sec = 8'd48;
        wait_edge(n + 44);
    endtask

    // sec=150 shows dashes; min=75 (60..99) shows as-is.
    task automatic test_out_of_range;
        int n;
        n   = ec + 1;
        sec = 8'd150;
        min = 8'd75;
        push_range(n, n + 30, 16'h1248, 16'h75AA, n + 9, 1'b0, n, n + 8, 4);
        wait_edge(n + 30);
    endtask

    // Set mode: blank in phase 0, normal digits plus dp on digit 2 in phase 1.
    task automatic test_blink;
        int n;
        n        = ec + 1;
        min      = 8'd5;
        sec      = 8'd9;
        blink_en = 1'b1;
        push_range(n + 10, n + 60, 16'h0509, 16'h0509, 0, 1'b1, 1, 0, 5);
        wait_edge(n + 60);
        blink_en = 1'b0;
    endtask

    // Reset mid-conversion: outputs go idle at once, display restarts at 00 00.
    task automatic test_reset_mid_conv;
        int n;
        n   = ec + 1;
        min = 8'd59;
        sec = 8'd59;
        push_range(n, n + 3, 16'h0509, 16'h0509, 0, 1'b0, n, n + 8, 6);
        wait_edge(n + 3);
        reset_p = 1'b1;
        #1;
        check_reset_outputs(6);
        repeat (2) @(negedge clk);
        reset_p = 1'b0;
        push_range(1, 40, 16'h0000, 16'h5959, 10, 1'b0, 1, 9, 7);
        wait_edge(40);
    endtask

    initial begin
        test_reset();
        test_convert();
        test_change_during_conv();
        test_out_of_range();
        test_blink();
        test_reset_mid_conv();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain left=%0d want=0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout edge=%0d", ec);
        $fatal(1, "bench timeout");
    end

endmodule
